// File: rtl/audio_in_pkg.sv
// Shared definitions for the I2S ADC capture path.
// Holds the sample width and per-channel FIFO depth, plus the sample and
// FIFO-count types used by audio_in_deserializer and audio_in_sync_fifo.
// No ports; imported with import audio_in_pkg::*.
package audio_in_pkg;

   localparam int AUDIO_DATA_WIDTH = 16;
   localparam int FIFO_DEPTH       = 8;
   localparam int FIFO_ADDR_WIDTH  = $clog2(FIFO_DEPTH);

   typedef logic [AUDIO_DATA_WIDTH-1:0] sample_t;
   // One bit wider than the address so a full FIFO (count == DEPTH) is representable.
   typedef logic [FIFO_ADDR_WIDTH:0]    fifo_count_t;

endpackage

// File: rtl/audio_in_sync_fifo.sv
// Single-clock show-ahead FIFO used once per audio channel.
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   clear          synchronous empty; wins over push and pop
//   push, push_data  write a word; dropped when full unless a pop happens too
//   pop            remove the head word; ignored when empty
//   head_data      current head word, 0 while empty
//   count          number of stored words, 0..DEPTH
module audio_in_sync_fifo
   import audio_in_pkg::*;
#(
   parameter int WIDTH      = AUDIO_DATA_WIDTH,
   parameter int DEPTH      = FIFO_DEPTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      push_data,
   output logic [WIDTH-1:0]      head_data,
   output logic [ADDR_WIDTH:0]   count
);

   localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [WIDTH-1:0]      mem_d [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  empty;
   logic                  full;
   logic                  do_push;
   logic                  do_pop;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a
   // push when it is popped. An empty FIFO ignores the pop but takes the push.
   always_comb begin
      empty    = (count_q == '0);
      full     = (count_q == FULL_COUNT);
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
         end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Stale memory contents are masked so an empty FIFO always reads as 0.
   assign head_data = empty ? '0 : mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/audio_in_deserializer.sv
// I2S ADC capture stage: shifts ADCDAT in MSB first on BCLK rising edges
// while the bit counter reports `counting`, and on each LRCK edge pushes the
// assembled word into the left (rising) or right (falling) FIFO.
// Ports:
//   clk, reset_n                 system clock, asynchronous active-low reset
//   clear_fifo                   empties both FIFOs, clears shift reg and overflow flags
//   bit_clk_rising_edge          BCLK rising-edge strobe
//   left_right_clk_rising_edge   LRCK rising-edge strobe, left word complete
//   left_right_clk_falling_edge  LRCK falling-edge strobe, right word complete
//   counting                     current bit belongs to the sample
//   serial_audio_in_data         ADCDAT, synchronised to clk
//   read_audio_in                pop the head of each non-empty FIFO
//   left/right_channel_data      show-ahead FIFO heads, 0 when empty
//   left/right_channel_fifo_count  words held per FIFO
//   left/right_overflow          sticky dropped-word flags
// Configuration macro: AUDIO_IN_OVERFLOW_EN enables the sticky overflow flags;
// without it both flag outputs are tied to 0 (full FIFOs still drop words).
module audio_in_deserializer
   import audio_in_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear_fifo,
   input  logic        bit_clk_rising_edge,
   input  logic        left_right_clk_rising_edge,
   input  logic        left_right_clk_falling_edge,
   input  logic        counting,
   input  logic        serial_audio_in_data,
   input  logic        read_audio_in,
   output sample_t     left_channel_data,
   output sample_t     right_channel_data,
   output fifo_count_t left_channel_fifo_count,
   output fifo_count_t right_channel_fifo_count,
   output logic        left_overflow,
   output logic        right_overflow
);

   sample_t shift_q, shift_d;
   logic    frame_edge;

   // A frame edge clears the shift register, so a BCLK bit arriving in the
   // same cycle is discarded rather than becoming the first bit of the next word.
   always_comb begin
      frame_edge = left_right_clk_rising_edge | left_right_clk_falling_edge;
      shift_d    = shift_q;
      if (clear_fifo || frame_edge) begin
         shift_d = '0;
      end else if (bit_clk_rising_edge && counting) begin
         shift_d = {shift_q[AUDIO_DATA_WIDTH-2:0], serial_audio_in_data};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shift_q <= '0;
      end else begin
         shift_q <= shift_d;
      end
   end

   audio_in_sync_fifo u_left_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear_fifo),
      .push      (left_right_clk_rising_edge),
      .pop       (read_audio_in),
      .push_data (shift_q),
      .head_data (left_channel_data),
      .count     (left_channel_fifo_count)
   );

   audio_in_sync_fifo u_right_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear_fifo),
      .push      (left_right_clk_falling_edge),
      .pop       (read_audio_in),
      .push_data (shift_q),
      .head_data (right_channel_data),
      .count     (right_channel_fifo_count)
   );

`ifdef AUDIO_IN_OVERFLOW_EN
   localparam fifo_count_t FULL_COUNT = fifo_count_t'(FIFO_DEPTH);

   logic left_overflow_q, left_overflow_d;
   logic right_overflow_q, right_overflow_d;

   // A push is only dropped when the FIFO is full and not being popped in the
   // same cycle; a pop on a full FIFO always succeeds and makes room.
   always_comb begin
      left_overflow_d  = left_overflow_q;
      right_overflow_d = right_overflow_q;
      if (clear_fifo) begin
         left_overflow_d  = 1'b0;
         right_overflow_d = 1'b0;
      end else begin
         if (left_right_clk_rising_edge && !read_audio_in &&
             (left_channel_fifo_count == FULL_COUNT)) begin
            left_overflow_d = 1'b1;
         end
         if (left_right_clk_falling_edge && !read_audio_in &&
             (right_channel_fifo_count == FULL_COUNT)) begin
            right_overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         left_overflow_q  <= 1'b0;
         right_overflow_q <= 1'b0;
      end else begin
         left_overflow_q  <= left_overflow_d;
         right_overflow_q <= right_overflow_d;
      end
   end

   assign left_overflow  = left_overflow_q;
   assign right_overflow = right_overflow_q;
`else
   assign left_overflow  = 1'b0;
   assign right_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_audio_in_deserializer.sv
// Self-checking bench for audio_in_deserializer: directed vector table,
// hand-written corner sequences and a randomized run against a queue-based
// reference model. Honours AUDIO_IN_OVERFLOW_EN for the expected flag values.
module tb_audio_in_deserializer;

`ifdef AUDIO_IN_OVERFLOW_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   localparam int W     = 16;
   localparam int DEPTH = 8;

   localparam int OP_LEFT  = 0;
   localparam int OP_RIGHT = 1;
   localparam int OP_READ  = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        clear_fifo;
   logic        bit_clk_rising_edge;
   logic        left_right_clk_rising_edge;
   logic        left_right_clk_falling_edge;
   logic        counting;
   logic        serial_audio_in_data;
   logic        read_audio_in;
   logic [15:0] left_channel_data;
   logic [15:0] right_channel_data;
   logic [3:0]  left_channel_fifo_count;
   logic [3:0]  right_channel_fifo_count;
   logic        left_overflow;
   logic        right_overflow;

   int check_count = 0;
   int error_count = 0;

   // Reference model state: sample queues per channel, bits received since last frame.
   logic [15:0] model_left[$];
   logic [15:0] model_right[$];
   bit          model_bits[$];
   bit          model_left_ovf;
   bit          model_right_ovf;

   typedef struct {
      int          op;
      logic [15:0] data;
      logic [15:0] exp_left;
      logic [15:0] exp_right;
      logic [3:0]  exp_left_count;
      logic [3:0]  exp_right_count;
   } vec_t;

   vec_t vecs[9];
   logic [15:0] words[10];

   audio_in_deserializer dut (
      .clk                         (clk),
      .reset_n                     (reset_n),
      .clear_fifo                  (clear_fifo),
      .bit_clk_rising_edge         (bit_clk_rising_edge),
      .left_right_clk_rising_edge  (left_right_clk_rising_edge),
      .left_right_clk_falling_edge (left_right_clk_falling_edge),
      .counting                    (counting),
      .serial_audio_in_data        (serial_audio_in_data),
      .read_audio_in               (read_audio_in),
      .left_channel_data           (left_channel_data),
      .right_channel_data          (right_channel_data),
      .left_channel_fifo_count     (left_channel_fifo_count),
      .right_channel_fifo_count    (right_channel_fifo_count),
      .left_overflow               (left_overflow),
      .right_overflow              (right_overflow)
   );

   // 50 MHz system clock.
   always #10 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   function automatic logic [15:0] model_word();
      logic [15:0] w;
      int          n;
      w = '0;
      n = model_bits.size();
      for (int i = 0; i < n; i++) begin
         w[n-1-i] = model_bits[i];
      end
      return w;
   endfunction

   task automatic model_reset();
      model_left.delete();
      model_right.delete();
      model_bits.delete();
      model_left_ovf  = 1'b0;
      model_right_ovf = 1'b0;
   endtask

   // Applies the current inputs to the model as one clock edge.
   task automatic model_edge();
      logic [15:0] w;
      if (!reset_n) begin
         model_reset();
         return;
      end
      if (clear_fifo) begin
         model_reset();
         return;
      end
      w = model_word();
      if (read_audio_in) begin
         if (model_left.size() > 0) void'(model_left.pop_front());
         if (model_right.size() > 0) void'(model_right.pop_front());
      end
      if (left_right_clk_rising_edge) begin
         if (model_left.size() < DEPTH) model_left.push_back(w);
         else if (OVF_EN) model_left_ovf = 1'b1;
      end
      if (left_right_clk_falling_edge) begin
         if (model_right.size() < DEPTH) model_right.push_back(w);
         else if (OVF_EN) model_right_ovf = 1'b1;
      end
      if (left_right_clk_rising_edge || left_right_clk_falling_edge) begin
         model_bits.delete();
      end else if (bit_clk_rising_edge && counting) begin
         model_bits.push_back(serial_audio_in_data);
         if (model_bits.size() > W) void'(model_bits.pop_front());
      end
   endtask

   task automatic check_against_model(input string tag);
      logic [15:0] exp_l;
      logic [15:0] exp_r;
      exp_l = (model_left.size() > 0) ? model_left[0] : 16'h0;
      exp_r = (model_right.size() > 0) ? model_right[0] : 16'h0;
      check_output({tag, "_left_data"}, 32'(left_channel_data), 32'(exp_l));
      check_output({tag, "_right_data"}, 32'(right_channel_data), 32'(exp_r));
      check_output({tag, "_left_count"}, 32'(left_channel_fifo_count), 32'(model_left.size()));
      check_output({tag, "_right_count"}, 32'(right_channel_fifo_count), 32'(model_right.size()));
      check_output({tag, "_left_ovf"}, 32'(left_overflow), 32'(model_left_ovf));
      check_output({tag, "_right_ovf"}, 32'(right_overflow), 32'(model_right_ovf));
   endtask

   task automatic idle_inputs();
      clear_fifo                  = 1'b0;
      bit_clk_rising_edge         = 1'b0;
      left_right_clk_rising_edge  = 1'b0;
      left_right_clk_falling_edge = 1'b0;
      counting                    = 1'b0;
      serial_audio_in_data        = 1'b0;
      read_audio_in               = 1'b0;
   endtask

   // One clock: DUT and model see the same inputs, outputs are sampled 1 ns later.
   task automatic apply_stimulus();
      @(posedge clk);
      model_edge();
      #1;
      idle_inputs();
   endtask

   task automatic send_bits(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         bit_clk_rising_edge  = 1'b1;
         counting             = 1'b1;
         serial_audio_in_data = bits[i];
         apply_stimulus();
      end
   endtask

   task automatic frame(input bit right, input bit with_read);
      left_right_clk_rising_edge  = ~right;
      left_right_clk_falling_edge = right;
      read_audio_in               = with_read;
      apply_stimulus();
   endtask

   task automatic do_clear();
      clear_fifo = 1'b1;
      apply_stimulus();
   endtask

   initial begin
      idle_inputs();
      reset_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      apply_stimulus();

      // Reset then idle.
      check_output("reset_left_data", 32'(left_channel_data), 32'h0);
      check_output("reset_right_data", 32'(right_channel_data), 32'h0);
      check_output("reset_left_count", 32'(left_channel_fifo_count), 32'h0);
      check_output("reset_right_count", 32'(right_channel_fifo_count), 32'h0);
      check_output("reset_left_ovf", 32'(left_overflow), 32'h0);
      check_output("reset_right_ovf", 32'(right_overflow), 32'h0);

      // Directed vector table: send/read operations with expected outputs after each.
      vecs[0] = '{OP_LEFT,  16'hA5C3, 16'hA5C3, 16'h0000, 4'd1, 4'd0};
      vecs[1] = '{OP_RIGHT, 16'h1234, 16'hA5C3, 16'h1234, 4'd1, 4'd1};
      vecs[2] = '{OP_READ,  16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0};
      vecs[3] = '{OP_LEFT,  16'h0F0F, 16'h0F0F, 16'h0000, 4'd1, 4'd0};
      vecs[4] = '{OP_LEFT,  16'hFFFF, 16'h0F0F, 16'h0000, 4'd2, 4'd0};
      vecs[5] = '{OP_RIGHT, 16'h8001, 16'h0F0F, 16'h8001, 4'd2, 4'd1};
      vecs[6] = '{OP_READ,  16'h0000, 16'hFFFF, 16'h0000, 4'd1, 4'd0};
      vecs[7] = '{OP_READ,  16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0};
      vecs[8] = '{OP_READ,  16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0};
      for (int v = 0; v < 9; v++) begin
         if (vecs[v].op == OP_READ) begin
            read_audio_in = 1'b1;
            apply_stimulus();
         end else begin
            send_bits(32'(vecs[v].data), W);
            frame(vecs[v].op == OP_RIGHT, 1'b0);
         end
         check_output($sformatf("vec%0d_left_data", v), 32'(left_channel_data), 32'(vecs[v].exp_left));
         check_output($sformatf("vec%0d_right_data", v), 32'(right_channel_data), 32'(vecs[v].exp_right));
         check_output($sformatf("vec%0d_left_count", v), 32'(left_channel_fifo_count), 32'(vecs[v].exp_left_count));
         check_output($sformatf("vec%0d_right_count", v), 32'(right_channel_fifo_count), 32'(vecs[v].exp_right_count));
      end

      // Nine left pushes into an 8-deep FIFO: ninth word dropped.
      for (int i = 0; i < 10; i++) words[i] = 16'($urandom);
      for (int i = 0; i < 9; i++) begin
         send_bits(32'(words[i]), W);
         frame(1'b0, 1'b0);
      end
      check_output("full_count", 32'(left_channel_fifo_count), 32'd8);
      check_output("full_head", 32'(left_channel_data), 32'(words[0]));
      check_output("full_ovf", 32'(left_overflow), 32'(OVF_EN));
      do_clear();
      check_output("clear_count", 32'(left_channel_fifo_count), 32'd0);
      check_output("clear_ovf", 32'(left_overflow), 32'd0);
      check_output("clear_data", 32'(left_channel_data), 32'd0);

      // Full FIFO with push and pop in the same cycle.
      for (int i = 0; i < 8; i++) begin
         send_bits(32'(words[i]), W);
         frame(1'b0, 1'b0);
      end
      send_bits(32'(words[8]), W);
      frame(1'b0, 1'b1);
      check_output("pushpop_count", 32'(left_channel_fifo_count), 32'd8);
      check_output("pushpop_head", 32'(left_channel_data), 32'(words[1]));
      check_output("pushpop_ovf", 32'(left_overflow), 32'd0);
      do_clear();

      // LRCK edge coincident with the 16th BCLK edge: that bit is lost.
      send_bits(32'h0000A5C3 >> 1, 15);
      bit_clk_rising_edge        = 1'b1;
      counting                   = 1'b1;
      serial_audio_in_data       = 1'b1;
      left_right_clk_rising_edge = 1'b1;
      apply_stimulus();
      check_output("coincide_left", 32'(left_channel_data), 32'h52E1);
      frame(1'b1, 1'b0);
      check_output("coincide_right_count", 32'(right_channel_fifo_count), 32'd1);
      check_output("coincide_right_data", 32'(right_channel_data), 32'h0);
      do_clear();

      // Short word (4 bits) and long word (20 bits, oldest 4 discarded).
      send_bits(32'hB, 4);
      frame(1'b0, 1'b0);
      check_output("short_word", 32'(left_channel_data), 32'h000B);
      send_bits(32'hF1234, 20);
      frame(1'b1, 1'b0);
      check_output("long_word", 32'(right_channel_data), 32'h1234);

      // Reset mid-word: everything clears at once, nothing pushed on release.
      send_bits(32'hC3, 8);
      #4;
      reset_n = 1'b0;
      model_reset();
      #2;
      check_output("async_left_count", 32'(left_channel_fifo_count), 32'd0);
      check_output("async_right_count", 32'(right_channel_fifo_count), 32'd0);
      check_output("async_left_data", 32'(left_channel_data), 32'd0);
      #5;
      reset_n = 1'b1;
      apply_stimulus();
      apply_stimulus();
      check_output("rel_left_count", 32'(left_channel_fifo_count), 32'd0);
      check_output("rel_right_count", 32'(right_channel_fifo_count), 32'd0);
      frame(1'b0, 1'b0);
      check_output("rel_partial_lost", 32'(left_channel_data), 32'd0);
      check_output("rel_push_count", 32'(left_channel_fifo_count), 32'd1);

      // Randomized traffic against the reference model.
      for (int c = 0; c < 1500; c++) begin
         int r;
         bit_clk_rising_edge  = ($urandom_range(0, 1) == 1);
         counting             = ($urandom_range(0, 9) < 8);
         serial_audio_in_data = 1'($urandom);
         r = $urandom_range(0, 99);
         left_right_clk_rising_edge  = (r < 4);
         left_right_clk_falling_edge = (r >= 4 && r < 8);
         read_audio_in        = ($urandom_range(0, 99) < 7);
         clear_fifo           = ($urandom_range(0, 299) == 0);
         apply_stimulus();
         check_against_model($sformatf("rand%0d", c));
      end

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
